// File: rtl/tlmon_pkg.sv
// Shared types, lamp pattern encodings and phase helpers for the traffic light monitor.
package tlmon_pkg;

    localparam int unsigned PAT_W   = 6;
    localparam int unsigned PHASE_W = 2;

    // Light phases in rotation order.
    typedef enum logic [PHASE_W-1:0] {
        PH_G1R2 = 2'd0,
        PH_Y1R2 = 2'd1,
        PH_R1G2 = 2'd2,
        PH_R1Y2 = 2'd3
    } phase_t;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Lamp pattern bit order: {l1_green, l1_yellow, l1_red, l2_green, l2_yellow, l2_red}.
    localparam logic [PAT_W-1:0] PAT_G1R2 = 6'b100_001;
    localparam logic [PAT_W-1:0] PAT_Y1R2 = 6'b010_001;
    localparam logic [PAT_W-1:0] PAT_R1G2 = 6'b001_100;
    localparam logic [PAT_W-1:0] PAT_R1Y2 = 6'b001_010;

    // Legal successor of a phase in the rotation.
    function automatic phase_t next_phase(input phase_t p);
        logic [PHASE_W-1:0] n;
        n = p + 2'd1;
        return phase_t'(n);
    endfunction

endpackage

// File: rtl/tlmon_dwell_timer.sv
// Dwell counter for the current phase: saturating, load-to-1, with bound compares
// against the green or yellow expectation.
module tlmon_dwell_timer
    import tlmon_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES  = 6000,
    parameter int unsigned YELLOW_CYCLES = 500,
    parameter int unsigned TOL           = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic inc_i,
    input  logic clr_i,
    input  logic yellow_i,
    output logic short_c_o,
    output logic long_c_o,
    output logic ovr_c_o
);

    localparam int unsigned CNT_W = $clog2(GREEN_CYCLES + TOL + 2);

    localparam logic [CNT_W-1:0] G_LO    = CNT_W'(GREEN_CYCLES - TOL);
    localparam logic [CNT_W-1:0] G_HI    = CNT_W'(GREEN_CYCLES + TOL);
    localparam logic [CNT_W-1:0] Y_LO    = CNT_W'(YELLOW_CYCLES - TOL);
    localparam logic [CNT_W-1:0] Y_HI    = CNT_W'(YELLOW_CYCLES + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] lo_thr;
    logic [CNT_W-1:0] hi_thr;

    // Next count: clear beats load beats saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Bound compares; ovr fires when the next increment would exceed the upper bound.
    always_comb begin
        lo_thr    = yellow_i ? Y_LO : G_LO;
        hi_thr    = yellow_i ? Y_HI : G_HI;
        short_c_o = (cnt_q < lo_thr);
        long_c_o  = (cnt_q > hi_thr);
        ovr_c_o   = (cnt_q == hi_thr);
    end

endmodule

// File: rtl/trafficlight_monitor.sv
// Passive traffic light checker: decodes lamp patterns into phases and flags illegal
// patterns, out-of-order phases and dwell violations. Define
// TRAFFICLIGHT_MONITOR_STICKY_EN to make the error outputs latch until reset.
module trafficlight_monitor
    import tlmon_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES  = 6000,
    parameter int unsigned YELLOW_CYCLES = 500,
    parameter int unsigned TOL           = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        light1_green,
    input  logic        light1_red,
    input  logic        light1_yellow,
    input  logic        light2_green,
    input  logic        light2_red,
    input  logic        light2_yellow,
    output logic [1:0]  phase,
    output logic        phase_valid,
    output logic        err_illegal,
    output logic        err_order,
    output logic        err_timing,
    output logic [15:0] cycles_done
);

    localparam int unsigned CYC_W = 16;

    logic [PAT_W-1:0] pat_c;
    logic             legal_c;
    phase_t           pat_phase_c;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic             partial_q, partial_d;
    logic             flagged_q, flagged_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             err_illegal_q, err_illegal_d;
    logic             err_order_q, err_order_d;
    logic             err_timing_q, err_timing_d;

    logic             ev_illegal, ev_order, ev_timing;
    logic             tmr_load, tmr_inc, tmr_clr;
    logic             tmr_short, tmr_long, tmr_ovr;

    assign pat_c = {light1_green, light1_yellow, light1_red,
                    light2_green, light2_yellow, light2_red};

    // Pattern decode: only the four one-lamp-per-light phase patterns are legal.
    always_comb begin
        legal_c     = 1'b1;
        pat_phase_c = PH_G1R2;
        case (pat_c)
            PAT_G1R2: pat_phase_c = PH_G1R2;
            PAT_Y1R2: pat_phase_c = PH_Y1R2;
            PAT_R1G2: pat_phase_c = PH_R1G2;
            PAT_R1Y2: pat_phase_c = PH_R1Y2;
            default:  legal_c     = 1'b0;
        endcase
    end

    tlmon_dwell_timer #(
        .GREEN_CYCLES  (GREEN_CYCLES),
        .YELLOW_CYCLES (YELLOW_CYCLES),
        .TOL           (TOL)
    ) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .inc_i     (tmr_inc),
        .clr_i     (tmr_clr),
        .yellow_i  (phase_q[0]),
        .short_c_o (tmr_short),
        .long_c_o  (tmr_long),
        .ovr_c_o   (tmr_ovr)
    );

    // Next-state, phase bookkeeping and error events.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        partial_d  = partial_q;
        flagged_d  = flagged_q;
        cycles_d   = cycles_q;
        ev_illegal = 1'b0;
        ev_order   = 1'b0;
        ev_timing  = 1'b0;
        tmr_load   = 1'b0;
        tmr_inc    = 1'b0;
        tmr_clr    = 1'b0;

        if (!legal_c) begin
            ev_illegal = 1'b1;
            state_d    = ST_SYNC;
            tmr_clr    = 1'b1;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    state_d   = ST_TRACK;
                    phase_d   = pat_phase_c;
                    partial_d = 1'b1;
                    flagged_d = 1'b0;
                    tmr_load  = 1'b1;
                end
                ST_TRACK: begin
                    if (pat_phase_c == phase_q) begin
                        tmr_inc = 1'b1;
                        if (tmr_ovr && !partial_q && !flagged_q) begin
                            ev_timing = 1'b1;
                            flagged_d = 1'b1;
                        end
                    end else if (pat_phase_c == next_phase(phase_q)) begin
                        if (!partial_q && !flagged_q && (tmr_short || tmr_long)) begin
                            ev_timing = 1'b1;
                        end
                        if (pat_phase_c == PH_G1R2) begin
                            cycles_d = cycles_q + CYC_W'(1);
                        end
                        phase_d   = pat_phase_c;
                        partial_d = 1'b0;
                        flagged_d = 1'b0;
                        tmr_load  = 1'b1;
                    end else begin
                        ev_order  = 1'b1;
                        phase_d   = pat_phase_c;
                        partial_d = 1'b1;
                        flagged_d = 1'b0;
                        tmr_load  = 1'b1;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end

`ifdef TRAFFICLIGHT_MONITOR_STICKY_EN
        err_illegal_d = err_illegal_q | ev_illegal;
        err_order_d   = err_order_q   | ev_order;
        err_timing_d  = err_timing_q  | ev_timing;
`else
        err_illegal_d = ev_illegal;
        err_order_d   = ev_order;
        err_timing_d  = ev_timing;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_SYNC;
            phase_q       <= PH_G1R2;
            partial_q     <= 1'b0;
            flagged_q     <= 1'b0;
            cycles_q      <= '0;
            err_illegal_q <= 1'b0;
            err_order_q   <= 1'b0;
            err_timing_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            partial_q     <= partial_d;
            flagged_q     <= flagged_d;
            cycles_q      <= cycles_d;
            err_illegal_q <= err_illegal_d;
            err_order_q   <= err_order_d;
            err_timing_q  <= err_timing_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = (state_q == ST_TRACK);
    assign err_illegal = err_illegal_q;
    assign err_order   = err_order_q;
    assign err_timing  = err_timing_q;
    assign cycles_done = cycles_q;

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Self-checking bench for trafficlight_monitor with GREEN=20, YELLOW=5, TOL=1.
module tb_trafficlight_monitor;

    localparam int G_EXP = 20;
    localparam int Y_EXP = 5;
    localparam int TOLV  = 1;
`ifdef TRAFFICLIGHT_MONITOR_STICKY_EN
    localparam int STICKY = 1;
`else
    localparam int STICKY = 0;
`endif

    // {l1g, l1y, l1r, l2g, l2y, l2r}
    localparam logic [5:0] P_G1R2 = 6'b100001;
    localparam logic [5:0] P_Y1R2 = 6'b010001;
    localparam logic [5:0] P_R1G2 = 6'b001100;
    localparam logic [5:0] P_R1Y2 = 6'b001010;
    localparam logic [5:0] P_BAD  = 6'b100100;

    logic        clk = 1'b0;
    logic        rst;
    logic        l1g, l1y, l1r, l2g, l2y, l2r;
    logic [1:0]  phase;
    logic        phase_valid, err_illegal, err_order, err_timing;
    logic [15:0] cycles_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          m_locked = 0;
    int          m_phase  = 0;
    int          m_run    = 0;
    int          m_checked  = 0;
    int          m_reported = 0;
    logic [15:0] m_cycles = 16'd0;
    int          m_ill = 0, m_ord = 0, m_tim = 0;

    trafficlight_monitor #(
        .GREEN_CYCLES  (20),
        .YELLOW_CYCLES (5),
        .TOL           (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .light1_green  (l1g),
        .light1_red    (l1r),
        .light1_yellow (l1y),
        .light2_green  (l2g),
        .light2_red    (l2r),
        .light2_yellow (l2y),
        .phase         (phase),
        .phase_valid   (phase_valid),
        .err_illegal   (err_illegal),
        .err_order     (err_order),
        .err_timing    (err_timing),
        .cycles_done   (cycles_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int decode(input logic [5:0] p);
        if (p == P_G1R2) return 0;
        if (p == P_Y1R2) return 1;
        if (p == P_R1G2) return 2;
        if (p == P_R1Y2) return 3;
        return -1;
    endfunction

    function automatic int expected_dwell(input int ph);
        return (ph % 2 == 0) ? G_EXP : Y_EXP;
    endfunction

    // Behavioural model: tracks runs of identical phases and judges each run's length.
    initial begin : model
        int ph, e_ill, e_ord, e_tim, ex;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_locked = 0; m_phase = 0; m_run = 0; m_checked = 0; m_reported = 0;
                m_cycles = 16'd0; m_ill = 0; m_ord = 0; m_tim = 0;
            end else begin
                ph = decode({l1g, l1y, l1r, l2g, l2y, l2r});
                e_ill = 0; e_ord = 0; e_tim = 0;
                if (ph < 0) begin
                    e_ill = 1;
                    m_locked = 0;
                end else if (m_locked == 0) begin
                    m_locked = 1; m_phase = ph; m_run = 1; m_checked = 0; m_reported = 0;
                end else if (ph == m_phase) begin
                    m_run = m_run + 1;
                    ex = expected_dwell(m_phase);
                    if (m_checked != 0 && m_reported == 0 && m_run > ex + TOLV) begin
                        e_tim = 1;
                        m_reported = 1;
                    end
                end else if (ph == (m_phase + 1) % 4) begin
                    ex = expected_dwell(m_phase);
                    if (m_checked != 0 && m_reported == 0 &&
                        (m_run < ex - TOLV || m_run > ex + TOLV)) e_tim = 1;
                    if (ph == 0) m_cycles = m_cycles + 16'd1;
                    m_phase = ph; m_run = 1; m_checked = 1; m_reported = 0;
                end else begin
                    e_ord = 1;
                    m_phase = ph; m_run = 1; m_checked = 0; m_reported = 0;
                end
                if (STICKY != 0) begin
                    m_ill = m_ill | e_ill; m_ord = m_ord | e_ord; m_tim = m_tim | e_tim;
                end else begin
                    m_ill = e_ill; m_ord = e_ord; m_tim = e_tim;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("phase_valid", int'(phase_valid), m_locked);
        if (m_locked != 0) chk("phase", int'(phase), m_phase);
        chk("err_illegal", int'(err_illegal), m_ill);
        chk("err_order", int'(err_order), m_ord);
        chk("err_timing", int'(err_timing), m_tim);
        chk("cycles_done", int'(cycles_done), int'(m_cycles));
    end

    task automatic hold(input logic [5:0] p, input int n);
        {l1g, l1y, l1r, l2g, l2y, l2r} = p;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        {l1g, l1y, l1r, l2g, l2y, l2r} = 6'b000000;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("lit_reset_valid", int'(phase_valid), 0);
        chk("lit_reset_cycles", int'(cycles_done), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Exact rotation, first phase unchecked
        hold(P_G1R2, 20);
        chk("lit_s1_lock_valid", int'(phase_valid), 1);
        chk("lit_s1_lock_phase", int'(phase), 0);
        hold(P_Y1R2, 5);
        hold(P_R1G2, 20);
        hold(P_R1Y2, 5);
        hold(P_G1R2, 1);
        chk("lit_s1_cycles", int'(cycles_done), 1);
        chk("lit_s1_phase0", int'(phase), 0);
        chk("lit_s1_no_timing", int'(err_timing), 0);
        hold(P_G1R2, 19);
        hold(P_Y1R2, 5);

        // Illegal glitch mid phase 2, relock unchecked
        hold(P_R1G2, 10);
        hold(P_BAD, 1);
        chk("lit_s2_illegal", int'(err_illegal), 1);
        chk("lit_s2_invalid", int'(phase_valid), 0);
        hold(P_R1G2, 1);
        chk("lit_s2_relock_valid", int'(phase_valid), 1);
        chk("lit_s2_relock_phase", int'(phase), 2);
        chk("lit_s2_illegal_after", int'(err_illegal), STICKY);
        hold(P_R1G2, 2);

        // Yellow too short, then green overrun
        hold(P_R1Y2, 3);
        hold(P_G1R2, 1);
        chk("lit_s4_short_yellow", int'(err_timing), 1);
        chk("lit_s4_cycles2", int'(cycles_done), 2);
        hold(P_G1R2, 21);
        chk("lit_s4_overrun", int'(err_timing), 1);
        hold(P_G1R2, 1);
        chk("lit_s4_overrun_once", int'(err_timing), STICKY);
        hold(P_Y1R2, 1);
        chk("lit_s4_no_exit_report", int'(err_timing), STICKY);
        hold(P_Y1R2, 3);
        hold(P_R1G2, 1);
        chk("lit_s4_yellow4_ok", int'(err_timing), STICKY);
        hold(P_R1G2, 19);
        hold(P_R1Y2, 6);
        hold(P_G1R2, 1);
        chk("lit_s4_yellow6_ok", int'(err_timing), STICKY);
        chk("lit_s4_cycles3", int'(cycles_done), 3);

        // Out-of-order jump G1R2 -> R1G2
        hold(P_G1R2, 4);
        hold(P_R1G2, 1);
        chk("lit_s3_order", int'(err_order), 1);
        chk("lit_s3_phase", int'(phase), 2);
        chk("lit_s3_timing_masked", int'(err_timing), STICKY);
        hold(P_R1G2, 2);
        hold(P_R1Y2, 5);
        hold(P_G1R2, 20);
        hold(P_Y1R2, 2);

        // Async reset mid phase 1
        rst = 1'b0;
        #1;
        chk("lit_s6_rst_valid", int'(phase_valid), 0);
        chk("lit_s6_rst_phase", int'(phase), 0);
        chk("lit_s6_rst_ill", int'(err_illegal), 0);
        chk("lit_s6_rst_ord", int'(err_order), 0);
        chk("lit_s6_rst_tim", int'(err_timing), 0);
        chk("lit_s6_rst_cycles", int'(cycles_done), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        hold(P_Y1R2, 3);
        chk("lit_s6_relock_valid", int'(phase_valid), 1);
        chk("lit_s6_relock_phase", int'(phase), 1);
        hold(P_R1G2, 3);
        chk("lit_s6_partial_exit", int'(err_timing), 0);
        chk("lit_s6_ill_cleared", int'(err_illegal), 0);

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
